// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and defaults for the FIFO byte serializer.
package fifo_pkg;
   localparam int DEF_DATA_WIDTH = 32;
   typedef logic [7:0] byte_t;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, CSUM} ser_state_e;
endpackage

// File: rtl/byte_shifter.sv
// byte_shifter: parallel-load word register shifted out MSB byte first, with byte index and done flag.
module byte_shifter
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  shift,
   output byte_t                 msb_byte,
   output logic                  done
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int IW = BYTES > 1 ? $clog2(BYTES) : 1;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [IW-1:0]         idx_q, idx_d;
   assign msb_byte = shift_q[DATA_WIDTH-1 -: 8];
   assign done     = idx_q == IW'(BYTES - 1);
   always_comb begin
      shift_d = load ? load_data : shift ? shift_q << 8 : shift_q;
      idx_d   = load ? '0 : shift ? (done ? '0 : idx_q + IW'(1)) : idx_q;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shift_q <= '0;
         idx_q   <= '0;
      end else begin
         shift_q <= shift_d;
         idx_q   <= idx_d;
      end
   end
endmodule

// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer: pops FIFO words and emits them MSB-first as a valid/ready byte stream with frame marking.
// Define SERIALIZER_CHECKSUM_EN to append an XOR checksum byte after each frame.
module fifo_byte_serializer
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int RD_LATENCY  = 1,
   parameter int FRAME_WORDS = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd,
   output byte_t                 byte_out,
   output logic                  byte_valid,
   input  logic                  byte_ready,
   output logic                  byte_last,
   output logic                  busy,
   output logic [15:0]           word_count
);
   localparam int FW = FRAME_WORDS > 1 ? $clog2(FRAME_WORDS) : 1;
   ser_state_e    state_q, state_d;
   logic [1:0]    lat_q, lat_d;
   logic [FW-1:0] frame_q, frame_d;
   logic [15:0]   word_count_q, word_count_d;
   logic          load, shift, done, hs, frame_last;
   byte_t         sh_byte;
   byte_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (load),
      .load_data(fifo_data),
      .shift    (shift),
      .msb_byte (sh_byte),
      .done     (done)
   );
   assign frame_last = frame_q == FW'(FRAME_WORDS - 1);
   assign hs         = byte_valid & byte_ready;
   assign fifo_rd    = state_q == REQ;
   assign busy       = state_q != IDLE;
   assign word_count = word_count_q;
`ifdef SERIALIZER_CHECKSUM_EN
   byte_t csum_q, csum_d;
   assign byte_valid = state_q == SEND || state_q == CSUM;
   assign byte_out   = state_q == SEND ? sh_byte : state_q == CSUM ? csum_q : 8'h00;
   assign byte_last  = state_q == CSUM;
   always_comb begin
      csum_d = csum_q;
      if (hs)
         csum_d = state_q == CSUM ? 8'h00 : csum_q ^ sh_byte;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) csum_q <= 8'h00;
      else          csum_q <= csum_d;
   end
`else
   assign byte_valid = state_q == SEND;
   assign byte_out   = state_q == SEND ? sh_byte : 8'h00;
   assign byte_last  = state_q == SEND && done && frame_last;
`endif
   always_comb begin
      state_d      = state_q;
      lat_d        = lat_q;
      frame_d      = frame_q;
      word_count_d = word_count_q;
      load         = 1'b0;
      shift        = 1'b0;
      case (state_q)
         IDLE: if (!fifo_empty) state_d = REQ;
         REQ: begin
            state_d = WAIT;
            lat_d   = 2'(RD_LATENCY - 1);
         end
         WAIT: begin
            if (lat_q == 2'd0) begin
               load    = 1'b1;
               state_d = SEND;
            end else begin
               lat_d = lat_q - 2'd1;
            end
         end
         SEND: begin
            if (hs) begin
               shift = 1'b1;
               if (done) begin
                  word_count_d = word_count_q + 16'd1;
                  frame_d      = frame_last ? '0 : frame_q + FW'(1);
`ifdef SERIALIZER_CHECKSUM_EN
                  state_d      = frame_last ? CSUM : IDLE;
`else
                  state_d      = IDLE;
`endif
               end
            end
         end
         CSUM: if (hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         lat_q        <= 2'd0;
         frame_q      <= '0;
         word_count_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         lat_q        <= lat_d;
         frame_q      <= frame_d;
         word_count_q <= word_count_d;
      end
   end
endmodule
